hazard_ctrl_param: RTL and testbench

//  Parametrised hazard/stall controller for the 7-stage pipe (F1,F2,DE,EX,M1,M2,WB).

---
 rtl/hazard_ctrl_param.sv | 183 ++++++++++++++++++
 tb/tb_hazard_ctrl_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_param.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_param
// Hazard/stall controller for a 7-stage pipe (F1,F2,DE,EX,M1,M2,WB).
// Detects a load in M1 feeding an operand read in EX or DE. Drains the rear pipe
// (EX..WB) before a CSR op leaves DE. Holds EX for multi-cycle ops (MUL/DIV).
// Drives the stall and flush strobes of the pipeline registers.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   de_valid/de_is_csr_op DE occupancy and CSR flag
//   de_rs/de_use_rs       DE source indices (operand i at [i*REG_AW +: REG_AW]) and read flags
//   ex_rs/ex_use_rs       EX source indices and read flags
//   ex_mc_start           first EX cycle of a multi-cycle op
//   m1_valid/m1_is_load/m1_rd  M1 occupancy, load flag and destination
//   rear_valid            per-stage valid, bit0=EX .. bit[PIPE_DEPTH-1]=WB
//   stall_pc/f2/de/ex     hold the stage register
//   flush_ex/flush_m1     insert a bubble into EX / M1
//   csr_busy              CSR FSM is draining (debug view of the FSM state)
//   mc_busy               multi-cycle counter is non-zero
//
// Optional feature: define HAZ_PERF_EN to add perf_lu_cnt, perf_csr_cnt and
// perf_mc_cnt. These are saturating 32-bit counts of the cycles won by each
// stall cause.
//
// Handshake: there is no valid/ready pair here. The strobes are level signals,
// and they are valid during the cycle in which their inputs are valid.
// -----------------------------------------------------------------------------
module hazard_ctrl_param #(
  parameter int REG_AW     = 5,
  parameter int NUM_RSRC   = 2,
  parameter int PIPE_DEPTH = 4,
  parameter int MC_LAT     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       de_valid,
  input  logic                       de_is_csr_op,
  input  logic [NUM_RSRC*REG_AW-1:0] de_rs,
  input  logic [NUM_RSRC-1:0]        de_use_rs,
  input  logic [NUM_RSRC*REG_AW-1:0] ex_rs,
  input  logic [NUM_RSRC-1:0]        ex_use_rs,
  input  logic                       ex_mc_start,
  input  logic                       m1_valid,
  input  logic                       m1_is_load,
  input  logic [REG_AW-1:0]          m1_rd,
  input  logic [PIPE_DEPTH-1:0]      rear_valid,
  output logic                       stall_pc,
  output logic                       stall_f2,
  output logic                       stall_de,
  output logic                       stall_ex,
  output logic                       flush_ex,
  output logic                       flush_m1,
  output logic                       csr_busy,
  output logic                       mc_busy
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]                perf_lu_cnt,
  output logic [31:0]                perf_csr_cnt,
  output logic [31:0]                perf_mc_cnt
`endif
);

  // With MC_LAT==1 the counter is always loaded with 0, so such an op never stalls.
  localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] MC_LOAD = CW'(MC_LAT - 1);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;
  typedef enum logic [2:0] {C_NONE, C_MC, C_LU_EX, C_LU_DE, C_CSR} cause_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   mc_cnt_q, mc_cnt_d;
  cause_t          cause;
  logic            ld_hit, ex_match, de_match, lu_ex, lu_de;
  logic            rear_any, csr_stall, mc_active;

  always_comb begin
    ex_match = 1'b0;
    de_match = 1'b0;
    for (int i = 0; i < NUM_RSRC; i++) begin
      if (ex_use_rs[i] && (ex_rs[i*REG_AW +: REG_AW] == m1_rd)) ex_match = 1'b1;
      if (de_use_rs[i] && (de_rs[i*REG_AW +: REG_AW] == m1_rd)) de_match = 1'b1;
    end
    // x0 is never written, so a load to x0 creates no dependency.
    ld_hit    = m1_valid & m1_is_load & (m1_rd != '0);
    lu_ex     = ld_hit & ex_match;
    lu_de     = ld_hit & de_match & de_valid;
    rear_any  = |rear_valid;
    mc_active = (mc_cnt_q != '0);
    csr_stall = (state_q == S_DRAIN) ? rear_any : (de_valid & de_is_csr_op & rear_any);

    // Exactly one cause wins each cycle. During reset nothing wins, so the
    // strobes drop at the moment rst rises.
    cause = C_NONE;
    if (rst)            cause = C_NONE;
    else if (mc_active) cause = C_MC;
    else if (lu_ex)     cause = C_LU_EX;
    else if (lu_de)     cause = C_LU_DE;
    else if (csr_stall) cause = C_CSR;

    stall_pc = 1'b0;
    stall_f2 = 1'b0;
    stall_de = 1'b0;
    stall_ex = 1'b0;
    flush_ex = 1'b0;
    flush_m1 = 1'b0;
    case (cause)
      C_MC, C_LU_EX: begin
        {stall_pc, stall_f2, stall_de, stall_ex} = 4'b1111;
        flush_m1 = 1'b1;
      end
      C_LU_DE, C_CSR: begin
        {stall_pc, stall_f2, stall_de} = 3'b111;
        flush_ex = 1'b1;
      end
      default: ;
    endcase

    // Multi-cycle occupancy: the start cycle counts as the first EX cycle.
    // The counter then covers the remaining MC_LAT-1 cycles.
    mc_cnt_d = mc_cnt_q;
    if (mc_active)                    mc_cnt_d = mc_cnt_q - CW'(1);
    else if (ex_mc_start && !lu_ex)   mc_cnt_d = MC_LOAD;

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cause == C_CSR) state_d = S_DRAIN;
      S_DRAIN: begin
        // A front flush (de_valid drops) abandons the drain. A higher-priority
        // cause leaves the drain pending. An empty rear pipe releases the CSR.
        if (!de_valid)                                              state_d = S_IDLE;
        else if (cause == C_MC || cause == C_LU_EX || cause == C_LU_DE) state_d = S_DRAIN;
        else if (!rear_any)                                         state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  assign csr_busy = (state_q == S_DRAIN);
  assign mc_busy  = mc_active;

`ifdef HAZ_PERF_EN
  logic [31:0] perf_lu_q, perf_lu_d, perf_csr_q, perf_csr_d, perf_mc_q, perf_mc_d;

  always_comb begin
    perf_lu_d  = perf_lu_q;
    perf_csr_d = perf_csr_q;
    perf_mc_d  = perf_mc_q;
    if ((cause == C_LU_EX || cause == C_LU_DE) && perf_lu_q != 32'hFFFF_FFFF)
      perf_lu_d = perf_lu_q + 32'd1;
    if (cause == C_CSR && perf_csr_q != 32'hFFFF_FFFF)
      perf_csr_d = perf_csr_q + 32'd1;
    if (cause == C_MC && perf_mc_q != 32'hFFFF_FFFF)
      perf_mc_d = perf_mc_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_q  <= '0;
      perf_csr_q <= '0;
      perf_mc_q  <= '0;
    end else begin
      perf_lu_q  <= perf_lu_d;
      perf_csr_q <= perf_csr_d;
      perf_mc_q  <= perf_mc_d;
    end
  end

  assign perf_lu_cnt  = perf_lu_q;
  assign perf_csr_cnt = perf_csr_q;
  assign perf_mc_cnt  = perf_mc_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_param
// Self-checking bench for hazard_ctrl_param. The configuration is NUM_RSRC=3
// and MC_LAT=4. A behavioural model holds three things: the number of
// multi-cycle EX cycles still owed, a "draining for a CSR" flag, and the
// per-cause cycle counts. Each cycle the model is checked against the DUT.
// The directed cases also pin literal strobe patterns.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_param;
  localparam int REG_AW     = 5;
  localparam int NUM_RSRC   = 3;
  localparam int PIPE_DEPTH = 4;
  localparam int MC_LAT     = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                       de_valid, de_is_csr_op, ex_mc_start;
  logic                       m1_valid, m1_is_load;
  logic [NUM_RSRC*REG_AW-1:0] de_rs, ex_rs;
  logic [NUM_RSRC-1:0]        de_use_rs, ex_use_rs;
  logic [REG_AW-1:0]          m1_rd;
  logic [PIPE_DEPTH-1:0]      rear_valid;
  logic stall_pc, stall_f2, stall_de, stall_ex, flush_ex, flush_m1, csr_busy, mc_busy;
`ifdef HAZ_PERF_EN
  logic [31:0] perf_lu_cnt, perf_csr_cnt, perf_mc_cnt;
`endif

  hazard_ctrl_param #(
    .REG_AW(REG_AW), .NUM_RSRC(NUM_RSRC), .PIPE_DEPTH(PIPE_DEPTH), .MC_LAT(MC_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .de_valid(de_valid), .de_is_csr_op(de_is_csr_op),
    .de_rs(de_rs), .de_use_rs(de_use_rs),
    .ex_rs(ex_rs), .ex_use_rs(ex_use_rs),
    .ex_mc_start(ex_mc_start),
    .m1_valid(m1_valid), .m1_is_load(m1_is_load), .m1_rd(m1_rd),
    .rear_valid(rear_valid),
    .stall_pc(stall_pc), .stall_f2(stall_f2), .stall_de(stall_de), .stall_ex(stall_ex),
    .flush_ex(flush_ex), .flush_m1(flush_m1),
    .csr_busy(csr_busy), .mc_busy(mc_busy)
`ifdef HAZ_PERF_EN
    ,
    .perf_lu_cnt(perf_lu_cnt), .perf_csr_cnt(perf_csr_cnt), .perf_mc_cnt(perf_mc_cnt)
`endif
  );

  // ---------------- stimulus state (operands as plain arrays) ----------------
  int de_rs_a [NUM_RSRC];
  int ex_rs_a [NUM_RSRC];
  bit de_use_a[NUM_RSRC];
  bit ex_use_a[NUM_RSRC];

  // ---------------- model state ----------------
  int m_mc_left;   // multi-cycle EX cycles still owed after the current one
  bit m_drain;     // a CSR in DE is waiting for the rear pipe to empty
  int m_lu, m_csr, m_mc;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_inputs();
    de_valid = 0; de_is_csr_op = 0; ex_mc_start = 0;
    m1_valid = 0; m1_is_load = 0; m1_rd = '0; rear_valid = '0;
    for (int i = 0; i < NUM_RSRC; i++) begin
      de_rs_a[i] = 0; ex_rs_a[i] = 0; de_use_a[i] = 0; ex_use_a[i] = 0;
    end
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < NUM_RSRC; i++) begin
      de_rs[i*REG_AW +: REG_AW] = REG_AW'(de_rs_a[i]);
      ex_rs[i*REG_AW +: REG_AW] = REG_AW'(ex_rs_a[i]);
      de_use_rs[i] = de_use_a[i];
      ex_use_rs[i] = ex_use_a[i];
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {stall_pc, stall_f2, stall_de, stall_ex, flush_ex, flush_m1, csr_busy, mc_busy};
  endfunction

  // The winning cause this cycle: 0 none, 1 mc, 2 lu_ex, 3 lu_de, 4 csr.
  function automatic int model_cause();
    bit load_dep, hit_ex, hit_de, csr_want;
    load_dep = m1_valid && m1_is_load && (int'(m1_rd) != 0);
    hit_ex = 0; hit_de = 0;
    for (int i = 0; i < NUM_RSRC; i++) begin
      if (ex_use_a[i] && ex_rs_a[i] == int'(m1_rd)) hit_ex = 1;
      if (de_use_a[i] && de_rs_a[i] == int'(m1_rd)) hit_de = 1;
    end
    csr_want = m_drain ? (rear_valid != 0) : (de_valid && de_is_csr_op && rear_valid != 0);
    if (m_mc_left > 0)                return 1;
    if (load_dep && hit_ex)           return 2;
    if (load_dep && hit_de && de_valid) return 3;
    if (csr_want)                     return 4;
    return 0;
  endfunction

  function automatic logic [7:0] model_vec(input int cause);
    logic [5:0] s;
    case (cause)
      1, 2:    s = 6'b1111_01;
      3, 4:    s = 6'b1110_10;
      default: s = 6'b0000_00;
    endcase
    return {s, m_drain, (m_mc_left > 0)};
  endfunction

  // One clock cycle: compare at the negative edge, then advance the model at the positive edge.
  task automatic step(input string name, input bit use_lit, input logic [7:0] lit);
    int cause;
    bit lu_ex_raw;
    pack_inputs();
    cause = model_cause();
    lu_ex_raw = 0;
    for (int i = 0; i < NUM_RSRC; i++)
      if (m1_valid && m1_is_load && m1_rd != 0 && ex_use_a[i] && ex_rs_a[i] == int'(m1_rd))
        lu_ex_raw = 1;
    @(negedge clk);
    check({name, "/model"}, 32'(dut_vec()), 32'(model_vec(cause)));
    if (use_lit) check({name, "/literal"}, 32'(dut_vec()), 32'(lit));
`ifdef HAZ_PERF_EN
    check({name, "/perf_lu"},  perf_lu_cnt,  32'(m_lu));
    check({name, "/perf_csr"}, perf_csr_cnt, 32'(m_csr));
    check({name, "/perf_mc"},  perf_mc_cnt,  32'(m_mc));
`endif
    @(posedge clk);
    if (cause == 2 || cause == 3) m_lu++;
    if (cause == 4) m_csr++;
    if (cause == 1) m_mc++;
    if (!m_drain)            m_drain = (cause == 4);
    else if (!de_valid)      m_drain = 0;
    else if (cause >= 1 && cause <= 3) m_drain = 1;
    else                     m_drain = (rear_valid != 0);
    if (m_mc_left > 0)                   m_mc_left--;
    else if (ex_mc_start && !lu_ex_raw)  m_mc_left = MC_LAT - 1;
    #1;
  endtask

  task automatic model_reset();
    m_mc_left = 0; m_drain = 0; m_lu = 0; m_csr = 0; m_mc = 0;
  endtask

  // Assert rst in the middle of a cycle, check outputs at once, release after an edge.
  task automatic mid_reset(input string name);
    #2 rst = 1'b1;
    #1;
    check({name, "/strobes_now"}, 32'(dut_vec()), 32'h0);
`ifdef HAZ_PERF_EN
    check({name, "/perf_zero"}, perf_lu_cnt | perf_csr_cnt | perf_mc_cnt, 32'h0);
`endif
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic randomize_inputs();
    de_valid     = ($urandom_range(0, 7) != 0);
    de_is_csr_op = ($urandom_range(0, 3) == 0);
    ex_mc_start  = ($urandom_range(0, 7) == 0);
    m1_valid     = $urandom_range(0, 1);
    m1_is_load   = $urandom_range(0, 1);
    m1_rd        = REG_AW'($urandom_range(0, 3));
    rear_valid   = ($urandom_range(0, 2) == 0) ? '0 : PIPE_DEPTH'($urandom);
    for (int i = 0; i < NUM_RSRC; i++) begin
      de_rs_a[i]  = $urandom_range(0, 3);
      ex_rs_a[i]  = $urandom_range(0, 3);
      de_use_a[i] = ($urandom_range(0, 2) == 0);
      ex_use_a[i] = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    pack_inputs();
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    step("reset", 1, 8'b0000_0000);

    // A load to x5 in M1, with EX reading x5 on operand 0: one cycle that holds EX and bubbles M1.
    m1_valid = 1; m1_is_load = 1; m1_rd = 5; ex_rs_a[0] = 5; ex_use_a[0] = 1;
    step("lu_ex", 1, 8'b1111_0100);
    clear_inputs();
    step("lu_ex_done", 1, 8'b0000_0000);

    // A load to x0 never creates a hazard.
    m1_valid = 1; m1_is_load = 1; m1_rd = 0; de_valid = 1; de_rs_a[0] = 0; de_use_a[0] = 1;
    ex_use_a[0] = 1;
    step("x0_exempt", 1, 8'b0000_0000);
    clear_inputs();

    // DE operand 2 reads the load destination.
    m1_valid = 1; m1_is_load = 1; m1_rd = 7; de_valid = 1; de_rs_a[2] = 7; de_use_a[2] = 1;
    ex_rs_a[0] = 3; ex_use_a[0] = 1;
    step("lu_de", 1, 8'b1110_1000);
    clear_inputs();
    step("lu_de_done", 1, 8'b0000_0000);

    // Multi-cycle op: the start cycle is free, then 3 busy cycles.
    ex_mc_start = 1;
    step("mc_start", 1, 8'b0000_0000);
    ex_mc_start = 0;
    m1_valid = 1; m1_is_load = 1; m1_rd = 9; de_valid = 1; de_rs_a[0] = 9; de_use_a[0] = 1;
    for (int k = 0; k < MC_LAT - 1; k++) step("mc_busy", 1, 8'b1111_0101);
    clear_inputs();
    step("mc_done", 1, 8'b0000_0000);

    // CSR drain: rear 0110, then 0010, then 0000 (CSR released on the third cycle).
    de_valid = 1; de_is_csr_op = 1; rear_valid = 4'b0110;
    step("csr_c1", 1, 8'b1110_1000);
    rear_valid = 4'b0010;
    step("csr_c2", 1, 8'b1110_1010);
    rear_valid = 4'b0000;
    step("csr_c3", 1, 8'b0000_0010);
    de_is_csr_op = 0;
    step("csr_idle", 1, 8'b0000_0000);

    // Reset while draining and while counting.
    de_valid = 1; de_is_csr_op = 1; rear_valid = 4'b1111;
    step("rst_setup_csr", 1, 8'b1110_1000);
    ex_mc_start = 1;
    step("rst_setup_mc", 1, 8'b1110_1010);
    ex_mc_start = 0;
    m1_valid = 1; m1_is_load = 1; m1_rd = 4; ex_rs_a[1] = 4; ex_use_a[1] = 1;
    pack_inputs();
    mid_reset("mid_rst");
    clear_inputs();
    step("post_rst", 1, 8'b0000_0000);

    // Random traffic, with one reset in the middle of the run.
    for (int c = 0; c < 2000; c++) begin
      randomize_inputs();
      if (c == 1000) begin
        pack_inputs();
        mid_reset("rand_rst");
      end
      step("rand", 0, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
